// File: rtl/range_ping_ctrl.sv
// Ultrasonic range sensor ping sequencer: fires periodic triggers, times the
// echo pulse in prescaled ticks and pushes one result word per ping to a FIFO.
module range_ping_ctrl #(
   parameter int DATA_WIDTH     = 16,
   parameter int TICK_CYCLES    = 100,
   parameter int TRIG_CYCLES    = 1000,
   parameter int TIMEOUT_CYCLES = 3_000_000,
   parameter int PERIOD_CYCLES  = 6_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  echo,
   input  logic                  full,
   output logic                  trig,
   output logic                  wr_en,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy,
   output logic                  overflow
);
   localparam int PER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
   localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int PS_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int WID_W = DATA_WIDTH - 1;

   localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
   localparam logic [PER_W-1:0] TRIG_LAST = PER_W'(TRIG_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(TICK_CYCLES - 1);
   localparam logic [WID_W-1:0] WID_MAX   = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_PUSH, S_HOLDOFF
   } state_t;

   state_t                r_state, w_next;
   logic                  r_echo_s1, r_echo_s2, r_echo_d;
   logic [PER_W-1:0]      r_per_cnt;
   logic [TO_W-1:0]       r_to_cnt;
   logic [PS_W-1:0]       r_presc;
   logic [WID_W-1:0]      r_width;
   logic [DATA_WIDTH-1:0] r_result, r_wr_data;
   logic                  r_trig, r_overflow;

   logic                  w_rise, w_fall, w_timeout, w_count, w_ps_wrap;
   logic [PS_W-1:0]       w_ps_base;
   logic [WID_W-1:0]      w_wid_base;

   assign w_rise    = r_echo_s2 & ~r_echo_d;
   assign w_fall    = ~r_echo_s2 & r_echo_d;
   assign w_timeout = ((r_state == S_WAIT_RISE) || (r_state == S_MEASURE)) &&
                      (r_to_cnt == TO_LAST);

   // The rise cycle is the first high cycle, so counting starts from a cleared base.
   assign w_count    = ((r_state == S_WAIT_RISE) & w_rise) |
                       ((r_state == S_MEASURE) & r_echo_s2);
   assign w_ps_base  = (r_state == S_MEASURE) ? r_presc : '0;
   assign w_wid_base = (r_state == S_MEASURE) ? r_width : '0;
   assign w_ps_wrap  = (w_ps_base == PS_LAST);

   always_comb begin
      w_next = r_state;
      wr_en  = 1'b0;
      case (r_state)
         S_IDLE:      if (en) w_next = S_TRIG;
         S_TRIG:      if (r_per_cnt == TRIG_LAST) w_next = S_WAIT_RISE;
         S_WAIT_RISE: if (w_timeout || w_rise) w_next = w_timeout ? S_PUSH : S_MEASURE;
         S_MEASURE:   if (w_timeout || w_fall) w_next = S_PUSH;
         S_PUSH: begin
            wr_en  = ~full;
            w_next = S_HOLDOFF;
         end
         S_HOLDOFF:   if (r_per_cnt == PER_LAST) w_next = en ? S_TRIG : S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_echo_s1  <= 1'b0;
         r_echo_s2  <= 1'b0;
         r_echo_d   <= 1'b0;
         r_per_cnt  <= '0;
         r_to_cnt   <= '0;
         r_presc    <= '0;
         r_width    <= '0;
         r_result   <= '0;
         r_wr_data  <= '0;
         r_trig     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_echo_s1 <= echo;
         r_echo_s2 <= r_echo_s1;
         r_echo_d  <= r_echo_s2;
         r_state   <= w_next;
         r_trig    <= (w_next == S_TRIG);

         // Period counter spans the whole ping so trigger spacing is fixed.
         if (((w_next == S_TRIG) && (r_state != S_TRIG)) || (w_next == S_IDLE))
            r_per_cnt <= '0;
         else if (r_state != S_IDLE)
            r_per_cnt <= r_per_cnt + 1'b1;

         if (r_state == S_TRIG)
            r_to_cnt <= '0;
         else if (((r_state == S_WAIT_RISE) || (r_state == S_MEASURE)) && !w_timeout)
            r_to_cnt <= r_to_cnt + 1'b1;

         if (w_count) begin
            r_presc <= w_ps_wrap ? '0 : w_ps_base + 1'b1;
            r_width <= (w_ps_wrap && (w_wid_base != WID_MAX)) ? w_wid_base + 1'b1 : w_wid_base;
         end

         if (w_next == S_PUSH)
            r_result <= w_timeout ? '1 : {1'b0, r_width};

         if (wr_en)
            r_wr_data <= r_result;

         if ((r_state == S_PUSH) && full)
            r_overflow <= 1'b1;
         else if ((r_state == S_IDLE) && !en)
            r_overflow <= 1'b0;
      end
   end

   assign trig     = r_trig;
   assign busy     = (r_state != S_IDLE);
   assign overflow = r_overflow;
   // Present the fresh result during the push cycle so the FIFO captures it on that edge.
   assign wr_data  = wr_en ? r_result : r_wr_data;

endmodule

// File: doc/range_ping_ctrl.md
# range_ping_ctrl

Ping-sequencing and echo-timing stage of the ultrasonic range sensor controller. Periodically issues a trigger pulse to the sensor, measures the width of the returned echo pulse in prescaled ticks, and pushes one result word per ping into the downstream first-word-fall-through FIFO write port (`wr_en`/`wr_data`), honouring the FIFO `full` flag. Handles echo timeout, FIFO overflow and enable gating.

## Interface
- `DATA_WIDTH`, 16: result word width; MSB is the timeout flag, the remaining `DATA_WIDTH-1` bits hold the width count.
- `TICK_CYCLES`, 100: clock cycles per width tick (1 us at 100 MHz).
- `TRIG_CYCLES`, 1000: trigger pulse length in cycles.
- `TIMEOUT_CYCLES`, 3_000_000: maximum cycles from trigger fall to echo fall.
- `PERIOD_CYCLES`, 6_000_000: cycles between successive trigger rising edges. Must be > `TRIG_CYCLES + TIMEOUT_CYCLES + 8`.

- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  enable periodic pinging.
- `echo`  in  1  raw sensor echo, asynchronous; internally synchronised.
- `full`  in  1  downstream FIFO full.
- `trig`  out  1  registered trigger to the sensor.
- `wr_en`  out  1  FIFO write strobe, single cycle.
- `wr_data`  out  `DATA_WIDTH`  result word; held until the next push.
- `busy`  out  1  high in every state except IDLE.
- `overflow`  out  1  sticky: a result was dropped because `full` was high.

## Operation
- `echo` passes through a 2-flop synchroniser (`echo_s1`, `echo_s2`) plus one history flop (`echo_d`). rise = `echo_s2 & ~echo_d`; fall = `~echo_s2 & echo_d`.
- IDLE: `en`=1 -> TRIG. `en`=0 -> clear `overflow`, remain.
- TRIG: `trig`=1 for exactly `TRIG_CYCLES` cycles; period counter restarts at 0 on entry. -> WAIT_RISE.
- WAIT_RISE: timeout counter runs from 0. rise -> MEASURE (width counter and prescaler cleared; the rise cycle counts as the first high cycle). A stuck-high `echo` gives no rise and therefore times out.
- MEASURE: prescaler counts each cycle `echo_s2`=1; on reaching `TICK_CYCLES-1` it wraps and the width counter increments, saturating at `2^(DATA_WIDTH-1)-1`. fall -> PUSH with `{1'b0, width}`.
- Timeout: timeout counter reaches `TIMEOUT_CYCLES-1` in WAIT_RISE or MEASURE -> PUSH with all ones (timeout flag set, width saturated). Timeout takes priority over a same-cycle rise or fall.
- PUSH: one cycle. `full`=0 -> `wr_en`=1, `wr_data` updated. `full`=1 -> `wr_en`=0, `wr_data` unchanged, `overflow` set. -> HOLDOFF.
- HOLDOFF: wait until the period counter reaches `PERIOD_CYCLES-1`. Then `en`=1 -> TRIG, `en`=0 -> IDLE.
- `en` is sampled only in IDLE and at the end of HOLDOFF. Deasserting it mid-ping lets the ping complete and push its result.
- Counter widths are `$clog2` of their limits. Period and timeout counters never wrap inside their states.

## Timing
- Reset values: `trig`=0, `wr_en`=0, `wr_data`=0, `busy`=0, `overflow`=0, state IDLE, all counters and synchroniser flops 0.
- Reset takes effect immediately at any point, including mid-TRIG (drops `trig`) or mid-MEASURE (no write).
- IDLE with `en`=1: `trig` rises 1 cycle later.
- Trigger-to-trigger spacing is exactly `PERIOD_CYCLES` while `en` stays 1, including timeout and overflow pings.
- Echo latency: `echo` sampled low at edge k gives `wr_en` high during the cycle after edge k+2; the write occurs at edge k+3.
- Width = floor(N / `TICK_CYCLES`), where N = cycles `echo_s2` is high from the rise-detect cycle up to (not including) the fall-detect cycle.
- Timeout push: `wr_en` high exactly `TIMEOUT_CYCLES+1` cycles after the last `trig`=1 cycle.

## Test plan
Parameters for all scenarios: `TICK_CYCLES`=4, `TRIG_CYCLES`=10, `TIMEOUT_CYCLES`=200, `PERIOD_CYCLES`=300, `DATA_WIDTH`=16.
- Reset with `en`=0 and `echo` toggling -> all outputs 0, `busy`=0, no `trig` for 50 cycles.
- `en`=1; `echo` high 40 cycles, starting 20 cycles after `trig` falls -> `trig` high exactly 10 cycles; a single `wr_en`; `wr_data`=0x000A; next `trig` rise 300 cycles after the first.
- `echo` held low -> `wr_en` 201 cycles after `trig` falls, `wr_data`=0xFFFF. Repeat with `echo` stuck high -> same result.
- `full`=1 throughout PUSH -> no `wr_en`, `wr_data` unchanged, `overflow`=1; next ping still at +300 cycles. `overflow` clears once `en`=0 reaches IDLE.
- `reset` pulsed mid-MEASURE -> `trig`=0, `busy`=0 immediately, no `wr_en`; after release with `en`=1, `trig` rises 1 cycle later.
- `en` dropped mid-MEASURE with a 12-cycle echo -> `wr_data`=0x0003 pushed; block enters IDLE after HOLDOFF; no further `trig`.
